// File: rtl/hawk_att_lkup_resp.sv
// hawk_att_lkup_resp: ATT lookup responder; reads a page's ATT entry, classifies it, allocates and writes back unmapped pages
// ports: lkup_* request handshake, mem_rd_*/mem_wr_* DRAM port, free_pg_* free-list head/pop,
//        allow/tbl_update/tbl_update_done/infl/lkup_err result pulses, lkup_ppa_o result page, *_cnt_o saturating stats
module hawk_att_lkup_resp #(
  parameter int HPPA_W = 20,
  parameter int PPA_W = 20,
  parameter int ADDR_W = 64,
  parameter logic [63:0] ATT_BASE = 64'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lkup_vld_i,
  input  logic [HPPA_W-1:0] lkup_hppa_i,
  output logic              lkup_rdy_o,
  output logic              mem_rd_req_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic              mem_rd_gnt_i,
  input  logic              mem_rd_vld_i,
  input  logic [63:0]       mem_rd_data_i,
  output logic              mem_wr_req_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [63:0]       mem_wr_data_o,
  input  logic              mem_wr_done_i,
  input  logic              free_pg_vld_i,
  input  logic [PPA_W-1:0]  free_pg_i,
  output logic              free_pg_pop_o,
  output logic              allow_cpu_access_o,
  output logic              tbl_update_o,
  output logic              tbl_update_done_o,
  output logic              infl_o,
  output logic              lkup_err_o,
  output logic [PPA_W-1:0]  lkup_ppa_o,
  output logic [15:0]       hit_cnt_o,
  output logic [15:0]       alloc_cnt_o
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, DECODE, ALLOC, WR_REQ, DONE} state_t;
  state_t st_q, st_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] cls_q;
  logic [PPA_W-1:0] pg_q, ppa_q;
  logic [15:0] hit_cnt_q, alloc_cnt_q;
  logic take_rd, take_wr, hit_d, allow_q, upd_q, done_q, infl_q, err_q;
  logic unused_rd;
  // only the state field and the PPA field of a read entry carry meaning
  assign unused_rd = ^(mem_rd_data_i >> PPA_W);
  assign take_rd = st_q == RD_WAIT && mem_rd_vld_i;
  assign take_wr = st_q == WR_REQ && mem_wr_done_i;
  assign hit_d = take_rd && mem_rd_data_i[63:62] == 2'b01;
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    st_d = lkup_vld_i ? RD_REQ : IDLE;
      RD_REQ:  st_d = mem_rd_gnt_i ? RD_WAIT : RD_REQ;
      RD_WAIT: st_d = mem_rd_vld_i ? DECODE : RD_WAIT;
      DECODE:  st_d = cls_q == 2'b00 ? ALLOC : IDLE;
      ALLOC:   st_d = free_pg_vld_i ? WR_REQ : ALLOC;
      WR_REQ:  st_d = mem_wr_done_i ? DONE : WR_REQ;
      default: st_d = IDLE;
    endcase
  end
  // result pulses are registered on the data/done cycle so they show up in DECODE/DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= IDLE;
      addr_q <= '0;
      cls_q <= '0;
      pg_q <= '0;
      ppa_q <= '0;
      allow_q <= 1'b0;
      upd_q <= 1'b0;
      done_q <= 1'b0;
      infl_q <= 1'b0;
      err_q <= 1'b0;
      hit_cnt_q <= '0;
      alloc_cnt_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == IDLE && lkup_vld_i) addr_q <= ADDR_W'(ATT_BASE) + ADDR_W'({lkup_hppa_i, 3'b000});
      if (take_rd) cls_q <= mem_rd_data_i[63:62];
      if (free_pg_pop_o) pg_q <= free_pg_i;
      allow_q <= hit_d;
      upd_q <= take_rd && mem_rd_data_i[63:62] == 2'b00;
      infl_q <= take_rd && mem_rd_data_i[63:62] == 2'b10;
      err_q <= take_rd && mem_rd_data_i[63:62] == 2'b11;
      done_q <= take_wr;
      if (hit_d) ppa_q <= mem_rd_data_i[PPA_W-1:0];
      else if (take_wr) ppa_q <= pg_q;
      if (hit_d && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (take_wr && alloc_cnt_q != 16'hFFFF) alloc_cnt_q <= alloc_cnt_q + 16'd1;
    end
  end
  assign lkup_rdy_o = st_q == IDLE;
  assign mem_rd_req_o = st_q == RD_REQ;
  assign mem_rd_addr_o = addr_q;
  assign mem_wr_req_o = st_q == WR_REQ;
  assign mem_wr_addr_o = addr_q;
  assign mem_wr_data_o = mem_wr_req_o ? (64'(pg_q) | {2'b01, 62'd0}) : '0;
  assign free_pg_pop_o = st_q == ALLOC && free_pg_vld_i;
  assign allow_cpu_access_o = allow_q;
  assign tbl_update_o = upd_q;
  assign tbl_update_done_o = done_q;
  assign infl_o = infl_q;
  assign lkup_err_o = err_q;
  assign lkup_ppa_o = ppa_q;
  assign hit_cnt_o = hit_cnt_q;
  assign alloc_cnt_o = alloc_cnt_q;
endmodule

// File: tb/tb_hawk_att_lkup_resp.sv
// tb_hawk_att_lkup_resp: randomized self-checking bench for hawk_att_lkup_resp against a transaction-level model
module tb_hawk_att_lkup_resp;
  localparam int HPPA_W = 20;
  localparam int PPA_W = 20;
  localparam int ADDR_W = 64;
  localparam logic [63:0] BASE = 64'h8000_0000;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic lkup_vld_i = 1'b0;
  logic [HPPA_W-1:0] lkup_hppa_i = '0;
  logic lkup_rdy_o, mem_rd_req_o, mem_wr_req_o, free_pg_pop_o;
  logic [ADDR_W-1:0] mem_rd_addr_o, mem_wr_addr_o;
  logic mem_rd_gnt_i = 1'b0, mem_rd_vld_i = 1'b0, mem_wr_done_i = 1'b0, free_pg_vld_i = 1'b0;
  logic [63:0] mem_rd_data_i = '0;
  logic [63:0] mem_wr_data_o;
  logic [PPA_W-1:0] free_pg_i = '0;
  logic allow_cpu_access_o, tbl_update_o, tbl_update_done_o, infl_o, lkup_err_o;
  logic [PPA_W-1:0] lkup_ppa_o;
  logic [15:0] hit_cnt_o, alloc_cnt_o;
  int passed = 0, total = 0;
  int m_hit = 0, m_alloc = 0;
  logic [PPA_W-1:0] m_ppa = '0;
  logic [63:0] o_rd_addr, o_wr_addr, o_wr_data;
  int o_allow, o_upd, o_done, o_infl, o_err, o_pop, o_lat, o_wr_reqs;
  logic [PPA_W-1:0] o_ppa;
  bit o_unstable, o_timeout, o_rdy_bad, o_pop_early;

  hawk_att_lkup_resp #(.HPPA_W(HPPA_W), .PPA_W(PPA_W), .ADDR_W(ADDR_W), .ATT_BASE(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .lkup_vld_i(lkup_vld_i), .lkup_hppa_i(lkup_hppa_i), .lkup_rdy_o(lkup_rdy_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_gnt_i(mem_rd_gnt_i),
    .mem_rd_vld_i(mem_rd_vld_i), .mem_rd_data_i(mem_rd_data_i), .mem_wr_req_o(mem_wr_req_o),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o), .mem_wr_done_i(mem_wr_done_i),
    .free_pg_vld_i(free_pg_vld_i), .free_pg_i(free_pg_i), .free_pg_pop_o(free_pg_pop_o),
    .allow_cpu_access_o(allow_cpu_access_o), .tbl_update_o(tbl_update_o), .tbl_update_done_o(tbl_update_done_o),
    .infl_o(infl_o), .lkup_err_o(lkup_err_o), .lkup_ppa_o(lkup_ppa_o), .hit_cnt_o(hit_cnt_o), .alloc_cnt_o(alloc_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic void model_update(input logic [1:0] c, input logic [63:0] e, input logic [PPA_W-1:0] fp);
    if (c == 2'b01) begin
      m_ppa = e[PPA_W-1:0];
      m_hit = m_hit < 65535 ? m_hit + 1 : 65535;
    end
    if (c == 2'b00) begin
      m_ppa = fp;
      m_alloc = m_alloc < 65535 ? m_alloc + 1 : 65535;
    end
  endfunction

  function automatic int exp_lat(input logic [1:0] c, input int gd, input int vd, input int fd, input int wd);
    return c == 2'b00 ? (fd >= 1 ? 3 + fd : 4) + gd + vd + 2 + wd : 3 + gd + vd;
  endfunction

  // memory/free-list responder: grant after gd req cycles, data vd cycles after grant,
  // free page fd cycles after tbl_update, write done after wd write-req cycles
  task automatic run_lookup(input logic [HPPA_W-1:0] h, input logic [63:0] ent, input int gd, input int vd,
                            input int fd, input logic [PPA_W-1:0] fp, input int wd);
    int rq, vc, fc;
    bit granted, got, upd_seen, fin;
    {o_allow, o_upd, o_done, o_infl, o_err, o_pop, o_lat, o_wr_reqs} = '0;
    {o_unstable, o_timeout, o_rdy_bad, o_pop_early} = '0;
    o_rd_addr = '0; o_wr_addr = '0; o_wr_data = '0; o_ppa = '0;
    for (int n = 0; n < 50 && !lkup_rdy_o; n++) @(negedge clk);
    lkup_vld_i = 1'b1;
    lkup_hppa_i = h;
    rq = 0; vc = 0; fc = 0; granted = 0; got = 0; upd_seen = 0; fin = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (lkup_rdy_o) o_rdy_bad = 1;
      if (mem_rd_req_o) begin
        if (rq == 0) o_rd_addr = mem_rd_addr_o;
        else if (mem_rd_addr_o !== o_rd_addr) o_unstable = 1;
        rq++;
      end
      if (mem_wr_req_o) begin
        if (o_wr_reqs == 0) begin
          o_wr_addr = mem_wr_addr_o;
          o_wr_data = mem_wr_data_o;
        end else if (mem_wr_addr_o !== o_wr_addr || mem_wr_data_o !== o_wr_data) o_unstable = 1;
        o_wr_reqs++;
      end
      o_allow += int'(allow_cpu_access_o);
      o_upd += int'(tbl_update_o);
      o_done += int'(tbl_update_done_o);
      o_infl += int'(infl_o);
      o_err += int'(lkup_err_o);
      if (tbl_update_o) upd_seen = 1;
      if (allow_cpu_access_o || tbl_update_done_o || infl_o || lkup_err_o) begin
        fin = 1;
        o_lat = n;
        o_ppa = lkup_ppa_o;
      end
      lkup_vld_i = !fin && !lkup_rdy_o && $urandom_range(0, 3) == 0;
      lkup_hppa_i = HPPA_W'($urandom);
      mem_rd_gnt_i = 1'b0;
      mem_rd_vld_i = 1'b0;
      mem_rd_data_i = {$urandom, $urandom};
      mem_wr_done_i = !fin && !mem_wr_req_o && $urandom_range(0, 1) == 1;
      free_pg_vld_i = 1'b0;
      free_pg_i = PPA_W'($urandom);
      if (!fin) begin
        if (mem_rd_req_o) begin
          if (rq - 1 == gd) begin
            mem_rd_gnt_i = 1'b1;
            mem_rd_vld_i = 1'b1;
            mem_rd_data_i = {2'b01, 62'($urandom)};
            granted = 1;
          end
        end else if (granted && !got) begin
          if (vc == vd) begin
            mem_rd_vld_i = 1'b1;
            mem_rd_data_i = ent;
            got = 1;
          end
          vc++;
        end
        if (mem_wr_req_o) mem_wr_done_i = o_wr_reqs - 1 == wd;
        if (upd_seen) begin
          free_pg_vld_i = fc >= fd;
          if (fc >= fd) free_pg_i = fp;
          fc++;
        end
      end
      #1;
      if (free_pg_pop_o) begin
        o_pop++;
        if (!free_pg_vld_i) o_pop_early = 1;
      end
      if (fin) break;
    end
    o_timeout = !fin;
    lkup_vld_i = 1'b0;
    mem_rd_gnt_i = 1'b0;
    mem_rd_vld_i = 1'b0;
    mem_wr_done_i = 1'b0;
    free_pg_vld_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({allow_cpu_access_o, tbl_update_o, tbl_update_done_o, infl_o, lkup_err_o, free_pg_pop_o, mem_rd_req_o, mem_wr_req_o} !== 8'h0)
      $display("FAIL reset_pulses got %b exp 0", {allow_cpu_access_o, tbl_update_o, tbl_update_done_o, infl_o, lkup_err_o, free_pg_pop_o, mem_rd_req_o, mem_wr_req_o});
    else passed++;
    total++;
    if (lkup_rdy_o !== 1'b1) $display("FAIL reset_rdy got %b exp 1", lkup_rdy_o); else passed++;
    total++;
    if ({mem_rd_addr_o, mem_wr_addr_o, mem_wr_data_o} !== 192'h0) $display("FAIL reset_addr_data got %h %h %h exp 0", mem_rd_addr_o, mem_wr_addr_o, mem_wr_data_o);
    else passed++;
    total++;
    if ({lkup_ppa_o, hit_cnt_o, alloc_cnt_o} !== '0) $display("FAIL reset_ppa_cnt got %h %h %h exp 0", lkup_ppa_o, hit_cnt_o, alloc_cnt_o);
    else passed++;
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hit;
    logic [63:0] e = 64'h4000_0000_0001_2345;
    run_lookup(20'h00005, e, 0, 0, 0, '0, 0);
    model_update(2'b01, e, '0);
    total++;
    if (o_timeout) $display("FAIL hit_timeout got none exp allow"); else passed++;
    total++;
    if (o_rd_addr !== 64'h8000_0028) $display("FAIL hit_addr got %h exp 80000028", o_rd_addr); else passed++;
    total++;
    if ({o_allow, o_upd, o_done, o_infl, o_err, o_pop} !== {32'd1, 160'd0}) $display("FAIL hit_pulses got %0d %0d %0d %0d %0d %0d exp 1 0 0 0 0 0", o_allow, o_upd, o_done, o_infl, o_err, o_pop);
    else passed++;
    total++;
    if (o_ppa !== 20'h12345) $display("FAIL hit_ppa got %h exp 12345", o_ppa); else passed++;
    total++;
    if (o_lat !== 3) $display("FAIL hit_latency got %0d exp 3", o_lat); else passed++;
    total++;
    if (hit_cnt_o !== 16'(m_hit)) $display("FAIL hit_cnt got %0d exp %0d", hit_cnt_o, m_hit); else passed++;
  endtask

  task automatic test_alloc;
    logic [HPPA_W-1:0] h = HPPA_W'($urandom);
    run_lookup(h, 64'h0, 1, 2, 4, 20'h00777, 0);
    model_update(2'b00, 64'h0, 20'h00777);
    total++;
    if (o_timeout || o_pop !== 1 || o_pop_early) $display("FAIL alloc_pop got t=%0d pops=%0d early=%0d exp 0 1 0", o_timeout, o_pop, o_pop_early);
    else passed++;
    total++;
    if (o_wr_data !== 64'h4000_0000_0000_0777) $display("FAIL alloc_wr_data got %h exp 4000000000000777", o_wr_data); else passed++;
    total++;
    if (o_wr_addr !== BASE + (64'(h) << 3) || o_rd_addr !== o_wr_addr) $display("FAIL alloc_wr_addr got %h/%h exp %h", o_rd_addr, o_wr_addr, BASE + (64'(h) << 3));
    else passed++;
    total++;
    if ({o_upd, o_done, o_ppa} !== {32'd1, 32'd1, 20'h00777}) $display("FAIL alloc_done got upd=%0d done=%0d ppa=%h exp 1 1 777", o_upd, o_done, o_ppa);
    else passed++;
    total++;
    if (alloc_cnt_o !== 16'(m_alloc)) $display("FAIL alloc_cnt got %0d exp %0d", alloc_cnt_o, m_alloc); else passed++;
    total++;
    if (o_lat !== exp_lat(2'b00, 1, 2, 4, 0)) $display("FAIL alloc_latency got %0d exp %0d", o_lat, exp_lat(2'b00, 1, 2, 4, 0)); else passed++;
  endtask

  task automatic test_comp_rsv;
    logic [63:0] ents [2] = '{64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000};
    for (int i = 0; i < 2; i++) begin
      run_lookup(HPPA_W'($urandom), ents[i], 0, 1, 0, '0, 0);
      total++;
      if ({o_allow, o_upd, o_done, o_infl, o_err, o_pop} !== {96'd0, 32'(i == 0), 32'(i == 1), 32'd0})
        $display("FAIL comp_rsv_pulses[%0d] got %0d %0d %0d %0d %0d %0d", i, o_allow, o_upd, o_done, o_infl, o_err, o_pop);
      else passed++;
      total++;
      if (o_wr_reqs !== 0 || o_ppa !== m_ppa) $display("FAIL comp_rsv_nowrite[%0d] got wr=%0d ppa=%h exp 0 %h", i, o_wr_reqs, o_ppa, m_ppa);
      else passed++;
      total++;
      if ({hit_cnt_o, alloc_cnt_o} !== {16'(m_hit), 16'(m_alloc)}) $display("FAIL comp_rsv_cnt[%0d] got %0d %0d exp %0d %0d", i, hit_cnt_o, alloc_cnt_o, m_hit, m_alloc);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    logic [PPA_W-1:0] fp = PPA_W'($urandom);
    run_lookup(HPPA_W'($urandom), 64'h0, 5, 0, 1, fp, 7);
    model_update(2'b00, 64'h0, fp);
    total++;
    if (o_unstable || o_rdy_bad || o_timeout) $display("FAIL bp_stable got unstable=%0d rdy=%0d timeout=%0d exp 0", o_unstable, o_rdy_bad, o_timeout);
    else passed++;
    total++;
    if (o_wr_reqs !== 8 || o_lat !== exp_lat(2'b00, 5, 0, 1, 7)) $display("FAIL bp_timing got wr_cycles=%0d lat=%0d exp 8 %0d", o_wr_reqs, o_lat, exp_lat(2'b00, 5, 0, 1, 7));
    else passed++;
    total++;
    if (o_ppa !== fp || alloc_cnt_o !== 16'(m_alloc)) $display("FAIL bp_result got %h %0d exp %h %0d", o_ppa, alloc_cnt_o, fp, m_alloc);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [63:0] e = {2'b01, 62'($urandom)};
    run_lookup(HPPA_W'($urandom), e, 0, 0, 0, '0, 0);
    model_update(2'b01, e, '0);
    @(negedge clk);
    total++;
    if (lkup_rdy_o !== 1'b1) $display("FAIL b2b_rdy got %b exp 1", lkup_rdy_o); else passed++;
    e = {2'b01, 62'($urandom)};
    run_lookup(HPPA_W'($urandom), e, 0, 0, 0, '0, 0);
    model_update(2'b01, e, '0);
    total++;
    if (o_lat !== 3 || o_ppa !== m_ppa) $display("FAIL b2b_second got lat=%0d ppa=%h exp 3 %h", o_lat, o_ppa, m_ppa); else passed++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [1:0] c = 2'($urandom_range(0, 3));
      logic [63:0] e = {c, 62'({$urandom, $urandom})};
      logic [HPPA_W-1:0] h = HPPA_W'($urandom);
      logic [PPA_W-1:0] fp = PPA_W'($urandom);
      int gd = $urandom_range(0, 4), vd = $urandom_range(0, 4), fd = $urandom_range(0, 4), wd = $urandom_range(0, 4);
      run_lookup(h, e, gd, vd, fd, fp, wd);
      model_update(c, e, fp);
      total++;
      if (o_rd_addr !== BASE + (64'(h) << 3)) $display("FAIL rnd_addr[%0d] got %h exp %h", i, o_rd_addr, BASE + (64'(h) << 3)); else passed++;
      total++;
      if ({o_allow, o_upd, o_done, o_infl, o_err, o_pop} !== {32'(c == 1), 32'(c == 0), 32'(c == 0), 32'(c == 2), 32'(c == 3), 32'(c == 0)})
        $display("FAIL rnd_pulses[%0d] cls=%0d got %0d %0d %0d %0d %0d %0d", i, c, o_allow, o_upd, o_done, o_infl, o_err, o_pop);
      else passed++;
      total++;
      if (o_ppa !== m_ppa) $display("FAIL rnd_ppa[%0d] got %h exp %h", i, o_ppa, m_ppa); else passed++;
      total++;
      if (o_lat !== exp_lat(c, gd, vd, fd, wd)) $display("FAIL rnd_latency[%0d] got %0d exp %0d", i, o_lat, exp_lat(c, gd, vd, fd, wd)); else passed++;
      total++;
      if ({o_unstable, o_rdy_bad, o_pop_early, o_timeout} !== 4'b0) $display("FAIL rnd_flags[%0d] got %b exp 0000", i, {o_unstable, o_rdy_bad, o_pop_early, o_timeout});
      else passed++;
      total++;
      if (c == 2'b00) begin
        if (o_wr_data !== ((64'h1 << 62) | 64'(fp)) || o_wr_addr !== o_rd_addr) $display("FAIL rnd_write[%0d] got %h @%h exp %h @%h", i, o_wr_data, o_wr_addr, (64'h1 << 62) | 64'(fp), o_rd_addr);
        else passed++;
      end else begin
        if (o_wr_reqs !== 0) $display("FAIL rnd_nowrite[%0d] got %0d exp 0", i, o_wr_reqs); else passed++;
      end
      total++;
      if ({hit_cnt_o, alloc_cnt_o} !== {16'(m_hit), 16'(m_alloc)}) $display("FAIL rnd_cnt[%0d] got %0d %0d exp %0d %0d", i, hit_cnt_o, alloc_cnt_o, m_hit, m_alloc);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit bad;
    @(negedge clk);
    lkup_vld_i = 1'b1;
    lkup_hppa_i = HPPA_W'($urandom);
    @(negedge clk);
    lkup_vld_i = 1'b0;
    for (n = 0; n < 10 && !mem_rd_req_o; n++) @(negedge clk);
    mem_rd_gnt_i = 1'b1;
    @(negedge clk);
    mem_rd_gnt_i = 1'b0;
    mem_rd_vld_i = 1'b1;
    mem_rd_data_i = 64'h0;
    @(negedge clk);
    mem_rd_vld_i = 1'b0;
    free_pg_vld_i = 1'b1;
    free_pg_i = PPA_W'($urandom);
    for (n = 0; n < 10 && !mem_wr_req_o; n++) @(negedge clk);
    total++;
    if (!mem_wr_req_o) $display("FAIL rstmid_reach_wr got wr_req=0 exp 1"); else passed++;
    rst_ni = 1'b0;
    m_hit = 0; m_alloc = 0; m_ppa = '0;
    #1;
    total++;
    if ({mem_wr_req_o, free_pg_pop_o, mem_rd_req_o, lkup_rdy_o, tbl_update_done_o} !== 5'b00010) $display("FAIL rstmid_ctrl got %b exp 00010", {mem_wr_req_o, free_pg_pop_o, mem_rd_req_o, lkup_rdy_o, tbl_update_done_o});
    else passed++;
    total++;
    if ({mem_wr_addr_o, mem_wr_data_o, lkup_ppa_o, hit_cnt_o, alloc_cnt_o} !== '0) $display("FAIL rstmid_data got %h %h %h %0d %0d exp 0", mem_wr_addr_o, mem_wr_data_o, lkup_ppa_o, hit_cnt_o, alloc_cnt_o);
    else passed++;
    @(negedge clk);
    rst_ni = 1'b1;
    mem_wr_done_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mem_wr_done_i = 1'b0;
      if (tbl_update_done_o || free_pg_pop_o || mem_wr_req_o || alloc_cnt_o != 0) bad = 1;
    end
    free_pg_vld_i = 1'b0;
    total++;
    if (bad) $display("FAIL rstmid_stray got activity after reset exp none"); else passed++;
  endtask

  task automatic test_saturation;
    force dut.hit_cnt_q = 16'hFFFD;
    @(negedge clk);
    release dut.hit_cnt_q;
    m_hit = 16'hFFFD;
    @(negedge clk);
    total++;
    if (hit_cnt_o !== 16'hFFFD) $display("FAIL sat_preload got %h exp fffd", hit_cnt_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      logic [63:0] e = {2'b01, 62'($urandom)};
      run_lookup(HPPA_W'($urandom), e, 0, 0, 0, '0, 0);
      model_update(2'b01, e, '0);
      total++;
      if (hit_cnt_o !== 16'(m_hit)) $display("FAIL sat_cnt[%0d] got %h exp %h", i, hit_cnt_o, 16'(m_hit)); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_alloc();
    test_comp_rsv();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
